// File: rtl/btb.sv
// ---------------------------------------------------------------------------
// btb - branch target buffer for the IF stage of the RV32IM pipeline.
//
// A 2-way set-associative table. Each entry holds a valid bit, a tag, a
// target and a 2-bit saturating direction counter. Each set has one LRU bit
// that names the way to evict next. The fetch PC is looked up
// combinationally. Branches resolved in EX update the table synchronously.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (clears every entry and LRU)
//   pc             fetch PC to look up
//   update_pc      PC of the resolved branch
//   update         resolved-branch write strobe (one update per cycle)
//   update_target  resolved taken target
//   mispredicted   1 = resolved not-taken, 0 = resolved taken to update_target
//   target_pc      predicted target on hit, else 0
//   valid          lookup hit
//   predictedTaken hit and counter MSB set
// ---------------------------------------------------------------------------
module btb #(
    parameter int SETS = 8,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update,
    input  logic [XLEN-1:0] update_target,
    input  logic            mispredicted,
    output logic [XLEN-1:0] target_pc,
    output logic            valid,
    output logic            predictedTaken
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = XLEN - INDEX_W - 2;

    // Entry storage, indexed [way][set]
    logic               r_valid  [2][SETS];
    logic [TAG_W-1:0]   r_tag    [2][SETS];
    logic [XLEN-1:0]    r_target [2][SETS];
    logic [1:0]         r_ctr    [2][SETS];
    logic               r_lru    [SETS];

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // The low two PC bits never select anything in the table
    logic w_unused_lo;
    assign w_unused_lo = ^{pc[1:0], update_pc[1:0]};

    // ---------------- lookup (combinational, no state change) -------------
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit0, w_hit1, w_hit, w_way;

    assign w_idx  = pc[INDEX_W+1:2];
    assign w_tag  = pc[XLEN-1:INDEX_W+2];
    assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit  = w_hit0 | w_hit1;
    // Tags never duplicate within a set, so way1 hitting identifies the way
    assign w_way  = w_hit1;

    assign valid          = w_hit;
    assign target_pc      = w_hit ? r_target[w_way][w_idx] : '0;
    assign predictedTaken = w_hit & r_ctr[w_way][w_idx][1];

    // ---------------- update-side decode ---------------------------------
    logic [INDEX_W-1:0] w_u_idx;
    logic [TAG_W-1:0]   w_u_tag;
    logic               w_u_hit0, w_u_hit1, w_u_hit, w_u_way, w_victim;

    assign w_u_idx  = update_pc[INDEX_W+1:2];
    assign w_u_tag  = update_pc[XLEN-1:INDEX_W+2];
    assign w_u_hit0 = r_valid[0][w_u_idx] && (r_tag[0][w_u_idx] == w_u_tag);
    assign w_u_hit1 = r_valid[1][w_u_idx] && (r_tag[1][w_u_idx] == w_u_tag);
    assign w_u_hit  = w_u_hit0 | w_u_hit1;
    assign w_u_way  = w_u_hit1;

    // Fill an empty way first (way0 before way1), otherwise evict the LRU way
    always_comb begin
        w_victim = r_lru[w_u_idx];
        if (!r_valid[0][w_u_idx])
            w_victim = 1'b0;
        else if (!r_valid[1][w_u_idx])
            w_victim = 1'b1;
    end

    // ---------------- state update ---------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    r_valid[w][s]  <= 1'b0;
                    r_tag[w][s]    <= '0;
                    r_target[w][s] <= '0;
                    r_ctr[w][s]    <= 2'b00;
                end
            end
        end else if (update) begin
            if (w_u_hit) begin
                if (mispredicted) begin
                    r_ctr[w_u_way][w_u_idx] <= sat_dec(r_ctr[w_u_way][w_u_idx]);
                end else begin
                    r_ctr[w_u_way][w_u_idx]    <= sat_inc(r_ctr[w_u_way][w_u_idx]);
                    r_target[w_u_way][w_u_idx] <= update_target;
                end
                r_lru[w_u_idx] <= ~w_u_way;
            end else if (!mispredicted) begin
                // A not-taken branch that misses is not worth allocating
                r_valid[w_victim][w_u_idx]  <= 1'b1;
                r_tag[w_victim][w_u_idx]    <= w_u_tag;
                r_target[w_victim][w_u_idx] <= update_target;
                r_ctr[w_victim][w_u_idx]    <= 2'b10;
                r_lru[w_u_idx]              <= ~w_victim;
            end
        end
    end

endmodule

// File: tb/tb_btb.sv
module tb_btb;
    localparam int SETS = 8;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] update_pc;
    logic            update;
    logic [XLEN-1:0] update_target;
    logic            mispredicted;
    logic [XLEN-1:0] target_pc;
    logic            valid;
    logic            predictedTaken;

    int total = 0;
    int bad   = 0;

    btb #(.SETS(SETS), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .pc(pc), .update_pc(update_pc), .update(update),
        .update_target(update_target), .mispredicted(mispredicted),
        .target_pc(target_pc), .valid(valid), .predictedTaken(predictedTaken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: each set is a recency-ordered list (front = most
    // recently touched), holding at most two branches keyed by pc[31:2].
    typedef struct {
        logic [29:0] key;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    ent_t m_set[SETS][$];

    function automatic int m_set_of(input logic [31:0] a);
        return int'(a[4:2]);
    endfunction

    function automatic int m_find(input logic [31:0] a);
        int s = m_set_of(a);
        foreach (m_set[s][i])
            if (m_set[s][i].key == a[31:2]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) m_set[s].delete();
    endtask

    task automatic m_update(input logic [31:0] a, input logic [31:0] t, input logic misp);
        int   s = m_set_of(a);
        int   p = m_find(a);
        ent_t e;
        if (p >= 0) begin
            e = m_set[s][p];
            if (misp) e.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
            else begin
                e.ctr = (e.ctr < 3) ? e.ctr + 1 : 3;
                e.tgt = t;
            end
            m_set[s].delete(p);
            m_set[s].push_front(e);
        end else if (!misp) begin
            if (m_set[s].size() == 2) void'(m_set[s].pop_back());
            e.key = a[31:2];
            e.tgt = t;
            e.ctr = 2;
            m_set[s].push_front(e);
        end
    endtask

    task automatic m_check(input string tag, input logic [31:0] a);
        int p = m_find(a);
        int s = m_set_of(a);
        if (p >= 0) begin
            check({tag, ".valid"}, {31'd0, valid}, 32'd1);
            check({tag, ".target"}, target_pc, m_set[s][p].tgt);
            check({tag, ".taken"}, {31'd0, predictedTaken}, (m_set[s][p].ctr >= 2) ? 32'd1 : 32'd0);
        end else begin
            check({tag, ".valid"}, {31'd0, valid}, 32'd0);
            check({tag, ".target"}, target_pc, 32'd0);
            check({tag, ".taken"}, {31'd0, predictedTaken}, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] a, input logic v,
                        input logic [31:0] t, input logic tk);
        pc = a;
        #1;
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        check({tag, ".target"}, target_pc, t);
        check({tag, ".taken"}, {31'd0, predictedTaken}, {31'd0, tk});
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic misp);
        update = 1'b1; update_pc = a; update_target = t; mispredicted = misp;
        tick();
        update = 1'b0; mispredicted = 1'b0;
    endtask

    localparam logic [31:0] PA = 32'h000A0000, TA = 32'h000A0020;
    localparam logic [31:0] PB = 32'h000B0000, TB = 32'h000B0020;
    localparam logic [31:0] PC_ = 32'h000C0000, TC = 32'h000D0020;
    localparam logic [31:0] PE = 32'h000E0000;

    initial begin
        logic [31:0] r_upc, r_tgt, r_pc;
        logic        r_upd, r_misp, r_rst;

        rst = 1'b1; pc = '0; update_pc = '0; update = 1'b0;
        update_target = '0; mispredicted = 1'b0;
        tick();
        rst = 1'b0;
        look("reset", PA, 1'b0, 32'h0, 1'b0);

        // Same-cycle lookup during the allocating update sees the old state
        update = 1'b1; update_pc = PA; update_target = TA; mispredicted = 1'b0;
        look("nobypass", PA, 1'b0, 32'h0, 1'b0);
        tick();
        update = 1'b0;
        look("allocA", PA, 1'b1, TA, 1'b1);

        upd(PB, TB, 1'b0);
        look("AafterB", PA, 1'b1, TA, 1'b1);
        look("allocB", PB, 1'b1, TB, 1'b1);

        upd(PB, 32'hDEAD0000, 1'b1);
        upd(PB, 32'hDEAD0000, 1'b1);
        look("Bdec", PB, 1'b1, TB, 1'b0);
        look("Aunch", PA, 1'b1, TA, 1'b1);

        // Not-taken miss must not allocate; update=0 ignores mispredicted
        upd(PE, 32'h1234, 1'b1);
        mispredicted = 1'b1; update_pc = PA; tick(); mispredicted = 1'b0;
        look("nomissalloc", PE, 1'b0, 32'h0, 1'b0);
        look("idleA", PA, 1'b1, TA, 1'b1);

        // idleA was only a lookup; B is still MRU so A is evicted
        upd(PC_, TC, 1'b0);
        look("Aevict", PA, 1'b0, 32'h0, 1'b0);
        look("Bkept", PB, 1'b1, TB, 1'b0);
        look("allocC", PC_, 1'b1, TC, 1'b1);

        // Saturation at 11: four increments, then one decrement is still taken
        for (int i = 0; i < 4; i++) upd(PC_, TC, 1'b0);
        look("sat11", PC_, 1'b1, TC, 1'b1);
        upd(PC_, TC, 1'b1);
        look("dec10", PC_, 1'b1, TC, 1'b1);
        upd(PC_, TC, 1'b1);
        look("dec01", PC_, 1'b1, TC, 1'b0);

        // Reset has priority over a simultaneous update
        rst = 1'b1; update = 1'b1; update_pc = PE; update_target = 32'h5555; mispredicted = 1'b0;
        tick();
        rst = 1'b0; update = 1'b0;
        look("rstE", PE, 1'b0, 32'h0, 1'b0);
        look("rstC", PC_, 1'b0, 32'h0, 1'b0);
        look("rstB", PB, 1'b0, 32'h0, 1'b0);

        // Randomized phase against the recency-list model
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            r_rst  = ($urandom_range(0, 199) == 0);
            r_upd  = ($urandom_range(0, 2) != 0);
            r_misp = ($urandom_range(0, 2) == 0);
            r_upc  = {$urandom_range(0, 3) * 32'd1 << 5} | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            r_upc  = r_upc | ({$urandom_range(0, 1)} << 20);
            r_pc   = {$urandom_range(0, 3) * 32'd1 << 5} | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            r_pc   = r_pc | ({$urandom_range(0, 1)} << 20);
            r_tgt  = $urandom;
            rst = r_rst; update = r_upd; mispredicted = r_misp;
            update_pc = r_upc; update_target = r_tgt; pc = r_pc;
            #2;
            m_check("rnd", r_pc);
            @(posedge clk);
            if (r_rst) m_reset();
            else if (r_upd) m_update(r_upc, r_tgt, r_misp);
            #1;
        end
        rst = 1'b0; update = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
